// File: rtl/wb_onehot_xbar.sv
// Single-master Wishbone classic router to N slaves, one-hot address-bit select, registered strobes/response.
// Optional slave timeout with bus error is enabled by defining WB_XBAR_TIMEOUT_EN.
module wb_onehot_xbar #(
  parameter int N_SLAVES       = 6,
  parameter int SEL_MSB        = 31,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m_cyc_i,
  input  logic                  m_stb_i,
  input  logic                  m_we_i,
  input  logic [3:0]            m_sel_i,
  input  logic [31:0]           m_adr_i,
  input  logic [31:0]           m_dat_i,
  output logic                  m_ack_o,
  output logic                  m_err_o,
  output logic [31:0]           m_dat_o,
  output logic [N_SLAVES-1:0]   s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [3:0]            s_sel_o,
  output logic [31:0]           s_adr_o,
  output logic [31:0]           s_dat_o,
  input  logic [N_SLAVES-1:0]   s_ack_i,
  input  logic [32*N_SLAVES-1:0] s_dat_i
);

  localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] dec_idx;
  logic             dec_hit;
  logic             sel_ack;
  logic [31:0]      rd_dat;

`ifdef WB_XBAR_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
`endif

  // Descending scan so the lowest matching slave index is the one left standing.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (m_adr_i[SEL_MSB-i]) begin
        dec_hit = 1'b1;
        dec_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    rd_dat = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (idx == IDX_W'(i)) rd_dat = s_dat_i[32*i +: 32];
    end
  end

  // s_cyc_o is one-hot while BUSY, so masking it filters out unselected acks.
  assign sel_ack = |(s_ack_i & s_cyc_o);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      m_ack_o <= 1'b0;
      m_err_o <= 1'b0;
      m_dat_o <= '0;
      s_cyc_o <= '0;
      s_stb_o <= 1'b0;
      s_we_o  <= 1'b0;
      s_sel_o <= '0;
      s_adr_o <= '0;
      s_dat_o <= '0;
`ifdef WB_XBAR_TIMEOUT_EN
      tmo_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (m_cyc_i && m_stb_i) begin
            if (dec_hit) begin
              idx     <= dec_idx;
              s_we_o  <= m_we_i;
              s_sel_o <= m_sel_i;
              s_adr_o <= m_adr_i;
              s_dat_o <= m_dat_i;
              s_cyc_o <= N_SLAVES'(1) << dec_idx;
              s_stb_o <= 1'b1;
`ifdef WB_XBAR_TIMEOUT_EN
              tmo_cnt <= '0;
`endif
              state   <= BUSY;
            end else begin
              m_err_o <= 1'b1;
              state   <= RESP;
            end
          end
        end
        BUSY: begin
          if (!m_cyc_i) begin
            s_cyc_o <= '0;
            s_stb_o <= 1'b0;
            state   <= IDLE;
          end else if (sel_ack) begin
            m_dat_o <= s_we_o ? 32'h0 : rd_dat;
            m_ack_o <= 1'b1;
            s_cyc_o <= '0;
            s_stb_o <= 1'b0;
            state   <= RESP;
          end
`ifdef WB_XBAR_TIMEOUT_EN
          // Counter holds BUSY cycles elapsed minus one; expiry on the TIMEOUT_CYCLES-th.
          else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            m_err_o <= 1'b1;
            s_cyc_o <= '0;
            s_stb_o <= 1'b0;
            state   <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          m_ack_o <= 1'b0;
          m_err_o <= 1'b0;
          m_dat_o <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_onehot_xbar.sv
// Directed bench for wb_onehot_xbar: decode, read/write, miss, spurious ack, wait/timeout, abort, reset.
module tb_wb_onehot_xbar;

  localparam int N = 6;

  logic            clk;
  logic            rst_n;
  logic            m_cyc_i, m_stb_i, m_we_i;
  logic [3:0]      m_sel_i;
  logic [31:0]     m_adr_i, m_dat_i;
  logic            m_ack_o, m_err_o;
  logic [31:0]     m_dat_o;
  logic [N-1:0]    s_cyc_o;
  logic            s_stb_o, s_we_o;
  logic [3:0]      s_sel_o;
  logic [31:0]     s_adr_o, s_dat_o;
  logic [N-1:0]    s_ack_i;
  logic [32*N-1:0] s_dat_i;

  int total = 0;
  int bad   = 0;

  wb_onehot_xbar #(.N_SLAVES(N), .SEL_MSB(31), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_sel_i(m_sel_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_ack_i(s_ack_i), .s_dat_i(s_dat_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] adr, input logic we, input logic [31:0] dat, input logic [3:0] sel);
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = we;
    m_adr_i = adr;  m_dat_i = dat;  m_sel_i = sel;
  endtask

  task automatic drop();
    m_cyc_i = 1'b0; m_stb_i = 1'b0; m_we_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    drop();
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
    s_ack_i = '0; s_dat_i = '0;
    #2;
    chk("rst_ack", 64'(m_ack_o), 64'd0);
    chk("rst_err", 64'(m_err_o), 64'd0);
    chk("rst_mdat", 64'(m_dat_o), 64'd0);
    chk("rst_scyc", 64'(s_cyc_o), 64'd0);
    chk("rst_sstb", 64'(s_stb_o), 64'd0);
    chk("rst_sadr", 64'(s_adr_o), 64'd0);
    #10 rst_n = 1'b1;

    // Read from slave 2, acked in the first strobe cycle.
    req(32'h2000_0004, 1'b0, 32'h0, 4'hF);
    cyc();
    chk("rd_scyc", 64'(s_cyc_o), 64'b000100);
    chk("rd_sstb", 64'(s_stb_o), 64'd1);
    chk("rd_sadr", 64'(s_adr_o), 64'h2000_0004);
    chk("rd_swe", 64'(s_we_o), 64'd0);
    chk("rd_ack_early", 64'(m_ack_o), 64'd0);
    s_ack_i = 6'b000100; s_dat_i[64 +: 32] = 32'hDEAD_BEEF;
    cyc();
    chk("rd_ack", 64'(m_ack_o), 64'd1);
    chk("rd_dat", 64'(m_dat_o), 64'hDEAD_BEEF);
    chk("rd_scyc_off", 64'(s_cyc_o), 64'd0);
    s_ack_i = '0; drop();
    cyc();
    chk("rd_ack_1cyc", 64'(m_ack_o), 64'd0);
    chk("rd_dat_clr", 64'(m_dat_o), 64'd0);

    // Write to slave 3; its read bus carries junk that must not reach m_dat_o.
    req(32'h1000_0000, 1'b1, 32'h0000_000F, 4'hF);
    cyc();
    chk("wr_scyc", 64'(s_cyc_o), 64'b001000);
    chk("wr_sdat", 64'(s_dat_o), 64'hF);
    chk("wr_swe", 64'(s_we_o), 64'd1);
    chk("wr_ssel", 64'(s_sel_o), 64'hF);
    s_ack_i = 6'b001000; s_dat_i[96 +: 32] = 32'h1234_5678;
    cyc();
    chk("wr_ack", 64'(m_ack_o), 64'd1);
    chk("wr_dat0", 64'(m_dat_o), 64'd0);
    s_ack_i = '0; drop();
    cyc();
    chk("wr_ack_1cyc", 64'(m_ack_o), 64'd0);

    // Decode miss: error in cycle 1, nothing strobed.
    req(32'h0000_0100, 1'b0, 32'h0, 4'hF);
    cyc();
    chk("miss_err", 64'(m_err_o), 64'd1);
    chk("miss_ack", 64'(m_ack_o), 64'd0);
    chk("miss_scyc", 64'(s_cyc_o), 64'd0);
    chk("miss_sstb", 64'(s_stb_o), 64'd0);
    drop();
    cyc();
    chk("miss_err_1cyc", 64'(m_err_o), 64'd0);
    cyc();

    // Two select bits: slave 0 wins; ack from slave 1 is ignored.
    req(32'hC000_0000, 1'b0, 32'h0, 4'hF);
    cyc();
    chk("prio_scyc", 64'(s_cyc_o), 64'b000001);
    s_ack_i = 6'b000010; s_dat_i[32 +: 32] = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("spur_ack", 64'(m_ack_o), 64'd0);
      chk("spur_scyc", 64'(s_cyc_o), 64'b000001);
    end
    s_ack_i = 6'b000001; s_dat_i[0 +: 32] = 32'hA5A5_5A5A;
    cyc();
    chk("prio_ack", 64'(m_ack_o), 64'd1);
    chk("prio_dat", 64'(m_dat_o), 64'hA5A5_5A5A);
    s_ack_i = '0; drop();
    cyc();
    cyc();

    // Slave 4 stays silent.
    req(32'h0800_0000, 1'b0, 32'h0, 4'hF);
    cyc();
    chk("wait_scyc", 64'(s_cyc_o), 64'b010000);
    s_dat_i[128 +: 32] = 32'h0BAD_F00D;
`ifdef WB_XBAR_TIMEOUT_EN
    for (int i = 1; i < 8; i++) begin
      cyc();
      chk("tmo_pre_err", 64'(m_err_o), 64'd0);
    end
    cyc();
    chk("tmo_err", 64'(m_err_o), 64'd1);
    chk("tmo_ack", 64'(m_ack_o), 64'd0);
    chk("tmo_scyc", 64'(s_cyc_o), 64'd0);
    drop();
    cyc();
    chk("tmo_err_1cyc", 64'(m_err_o), 64'd0);
    // Ack landing on the expiry cycle takes precedence.
    req(32'h0800_0000, 1'b0, 32'h0, 4'hF);
    cyc();
    for (int i = 1; i < 8; i++) cyc();
    s_ack_i = 6'b010000;
    cyc();
    chk("tmo_race_ack", 64'(m_ack_o), 64'd1);
    chk("tmo_race_err", 64'(m_err_o), 64'd0);
    chk("tmo_race_dat", 64'(m_dat_o), 64'h0BAD_F00D);
`else
    for (int i = 0; i < 20; i++) cyc();
    chk("wait_err", 64'(m_err_o), 64'd0);
    chk("wait_sstb", 64'(s_stb_o), 64'd1);
    s_ack_i = 6'b010000;
    cyc();
    chk("wait_ack", 64'(m_ack_o), 64'd1);
    chk("wait_dat", 64'(m_dat_o), 64'h0BAD_F00D);
`endif
    s_ack_i = '0; drop();
    cyc();
    cyc();

    // Master abort in BUSY, then stray ack in IDLE.
    req(32'h4000_0000, 1'b0, 32'h0, 4'hF);
    cyc();
    chk("abt_scyc_on", 64'(s_cyc_o), 64'b000010);
    drop();
    cyc();
    chk("abt_scyc", 64'(s_cyc_o), 64'd0);
    chk("abt_sstb", 64'(s_stb_o), 64'd0);
    s_ack_i = 6'b000010;
    cyc();
    chk("abt_ack", 64'(m_ack_o), 64'd0);
    chk("abt_err", 64'(m_err_o), 64'd0);
    s_ack_i = '0;
    req(32'h0400_0000, 1'b0, 32'h0, 4'hF);
    cyc();
    chk("post_abt_scyc", 64'(s_cyc_o), 64'b100000);
    s_ack_i = 6'b100000; s_dat_i[160 +: 32] = 32'h5555_AAAA;
    cyc();
    chk("post_abt_ack", 64'(m_ack_o), 64'd1);
    chk("post_abt_dat", 64'(m_dat_o), 64'h5555_AAAA);
    s_ack_i = '0; drop();
    cyc();

    // Reset pulse mid-BUSY clears slave strobes immediately.
    req(32'h2000_0000, 1'b0, 32'h0, 4'hF);
    cyc();
    chk("rstb_scyc_on", 64'(s_cyc_o), 64'b000100);
    rst_n = 1'b0;
    #1;
    chk("rstb_scyc", 64'(s_cyc_o), 64'd0);
    chk("rstb_sadr", 64'(s_adr_o), 64'd0);
    drop();
    s_ack_i = 6'b000100;
    #2 rst_n = 1'b1;
    cyc();
    chk("rstb_ack", 64'(m_ack_o), 64'd0);
    chk("rstb_scyc2", 64'(s_cyc_o), 64'd0);
    s_ack_i = '0;
    req(32'h2000_0000, 1'b0, 32'h0, 4'hF);
    cyc();
    s_ack_i = 6'b000100; s_dat_i[64 +: 32] = 32'hCAFE_0001;
    cyc();
    chk("rstb_post_ack", 64'(m_ack_o), 64'd1);
    chk("rstb_post_dat", 64'(m_dat_o), 64'hCAFE_0001);
    s_ack_i = '0; drop();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
